paddle_input_mapper: RTL and testbench

//  Parametrised N-player control front end for paddle-era arcade cores.
//  - Merges PS/2 keys, digital joysticks and analog sticks into per-player paddle positions.
//  - Produces start levels and one debounced coin pulse.
//  - Sits between hps_io and the game core, in the clk_sys domain.
//  - Adds features over the fixed 2-player analog mapping:
//    - digital up/down paddle integration with saturation;
//    - per-player analog/digital mode select;
//    - a stretched coin pulse.

---
 rtl/paddle_input_mapper.sv | 210 +++++++++++++++++++++
 tb/tb_paddle_input_mapper.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_input_mapper.sv
`default_nettype none
// ============================================================================
// paddle_input_mapper : PS/2 + joystick + analog stick -> paddles, start, coin
// Revision: 1.0
// ============================================================================
module paddle_input_mapper #(
    parameter int NUM_PLAYERS = 2,
    parameter int POS_W       = 8,
    parameter int POS_MIN     = 0,
    parameter int POS_MAX     = 255,
    parameter int STEP        = 4,
    parameter int TICK_DIV    = 7159,
    parameter int COIN_LEN    = 71590
) (
    input  logic                         clk_sys,
    input  logic                         reset,
    input  logic [10:0]                  ps2_key,
    input  logic [16*NUM_PLAYERS-1:0]    joystick,
    input  logic [16*NUM_PLAYERS-1:0]    joystick_analog,
    input  logic [NUM_PLAYERS-1:0]       mode_digital,
    input  logic                         ext_coin,
    output logic [POS_W*NUM_PLAYERS-1:0] paddle_pos,
    output logic [NUM_PLAYERS-1:0]       start,
    output logic                         coin
);

    localparam int XW     = POS_W + 1;
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int COIN_W = (COIN_LEN > 1) ? $clog2(COIN_LEN) : 1;
    localparam logic [POS_W-1:0] c_CENTER = POS_W'((POS_MIN + POS_MAX) / 2);
    localparam logic [POS_W-1:0] c_MIN    = POS_W'(POS_MIN);
    localparam logic [POS_W-1:0] c_MAX    = POS_W'(POS_MAX);

    // ---------------- keyboard latches ----------------
    logic       r_ps2_prev;
    logic       r_ps2_armed;
    logic [1:0] r_key_start;
    logic [1:0] r_key_up;
    logic [1:0] r_key_dn;
    logic       r_key_coin5;
    logic       r_key_coin6;
    logic       w_key_evt;

    // The first sample after reset only seeds the toggle reference
    assign w_key_evt = r_ps2_armed & (ps2_key[10] ^ r_ps2_prev);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_ps2_prev  <= 1'b0;
            r_ps2_armed <= 1'b0;
            r_key_start <= 2'b00;
            r_key_up    <= 2'b00;
            r_key_dn    <= 2'b00;
            r_key_coin5 <= 1'b0;
            r_key_coin6 <= 1'b0;
        end else begin
            r_ps2_prev  <= ps2_key[10];
            r_ps2_armed <= 1'b1;
            if (w_key_evt) begin
                case (ps2_key[8:0])
                    9'h016, 9'h005: r_key_start[0] <= ps2_key[9];
                    9'h01E, 9'h006: r_key_start[1] <= ps2_key[9];
                    9'h02E:         r_key_coin5    <= ps2_key[9];
                    9'h036:         r_key_coin6    <= ps2_key[9];
                    9'h01D:         r_key_up[0]    <= ps2_key[9];
                    9'h01B:         r_key_dn[0]    <= ps2_key[9];
                    9'h175:         r_key_up[1]    <= ps2_key[9];
                    9'h172:         r_key_dn[1]    <= ps2_key[9];
                    default: ;
                endcase
            end
        end
    end

    // ---------------- digital tick ----------------
    logic [TICK_W-1:0] r_tick_cnt;
    logic              w_tick;

    assign w_tick = (r_tick_cnt == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            r_tick_cnt <= '0;
        else if (w_tick)
            r_tick_cnt <= '0;
        else
            r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    // ---------------- per-player paddle and start ----------------
    logic [NUM_PLAYERS-1:0] w_joy_coin;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic             w_kup, w_kdn, w_kst;
        logic             w_up, w_dn;
        logic [7:0]       w_y;
        logic [POS_W-1:0] w_ana_raw, w_ana, w_next, w_dec;
        logic [XW-1:0]    w_pos_x, w_inc;
        logic             w_dec_ok;
        logic [POS_W-1:0] r_pos;
        logic             r_start;
        logic             w_unused_p;

        if (p < 2) begin : g_keys
            assign w_kup = r_key_up[p];
            assign w_kdn = r_key_dn[p];
            assign w_kst = r_key_start[p];
        end else begin : g_nokeys
            assign w_kup = 1'b0;
            assign w_kdn = 1'b0;
            assign w_kst = 1'b0;
        end

        assign w_up          = w_kup | joystick[p*16+3];
        assign w_dn          = w_kdn | joystick[p*16+2];
        assign w_joy_coin[p] = joystick[p*16+5];
        assign w_unused_p    = ^{joystick[p*16+6 +: 10], joystick[p*16 +: 2],
                                 joystick_analog[p*16 +: 8]};

        // Offset-binary conversion of the signed stick, scaled to the top byte
        assign w_y       = joystick_analog[p*16+8 +: 8];
        assign w_ana_raw = POS_W'(w_y ^ 8'h80) << (POS_W - 8);
        assign w_ana     = (w_ana_raw < c_MIN) ? c_MIN :
                           (w_ana_raw > c_MAX) ? c_MAX : w_ana_raw;

        assign w_pos_x  = {1'b0, r_pos};
        assign w_inc    = w_pos_x + XW'(STEP);
        assign w_dec_ok = (w_pos_x >= XW'(POS_MIN + STEP));
        assign w_dec    = r_pos - POS_W'(STEP);

        always_comb begin
            w_next = r_pos;
            if (!mode_digital[p]) begin
                w_next = w_ana;
            end else if (w_tick && w_up && !w_dn) begin
                w_next = w_dec_ok ? w_dec : c_MIN;
            end else if (w_tick && w_dn && !w_up) begin
                w_next = (w_inc > {1'b0, c_MAX}) ? c_MAX : w_inc[POS_W-1:0];
            end
        end

        always_ff @(posedge clk_sys or posedge reset) begin
            if (reset) begin
                r_pos   <= c_CENTER;
                r_start <= 1'b0;
            end else begin
                r_pos   <= w_next;
                r_start <= w_kst | joystick[p*16+4];
            end
        end

        assign paddle_pos[p*POS_W +: POS_W] = r_pos;
        assign start[p]                     = r_start;
    end

    // ---------------- coin pulse FSM ----------------
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PULSE    = 2'd1,
        S_WAIT_REL = 2'd2
    } coin_state_t;

    coin_state_t       r_state, w_state_next;
    logic [COIN_W-1:0] r_coin_cnt, w_coin_cnt_next;
    logic              r_src, r_src_d;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_src      <= 1'b0;
            r_src_d    <= 1'b0;
            r_state    <= S_IDLE;
            r_coin_cnt <= '0;
        end else begin
            r_src      <= r_key_coin5 | r_key_coin6 | (|w_joy_coin) | ext_coin;
            r_src_d    <= r_src;
            r_state    <= w_state_next;
            r_coin_cnt <= w_coin_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_coin_cnt_next = r_coin_cnt;
        case (r_state)
            S_IDLE: begin
                if (r_src && !r_src_d) begin
                    w_state_next    = S_PULSE;
                    w_coin_cnt_next = COIN_W'(COIN_LEN - 1);
                end
            end
            S_PULSE: begin
                // Source edges here are ignored: no retrigger, no extension
                if (r_coin_cnt == '0)
                    w_state_next = r_src ? S_WAIT_REL : S_IDLE;
                else
                    w_coin_cnt_next = r_coin_cnt - 1'b1;
            end
            S_WAIT_REL: begin
                if (!r_src)
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Decoded straight from the state register so reset drops it at once
    assign coin = (r_state == S_PULSE);

endmodule
`default_nettype wire

// File: tb/tb_paddle_input_mapper.sv
`default_nettype none
// ============================================================================
// tb_paddle_input_mapper : directed stimulus, queued expectations, negedge monitors
// Revision: 1.0
// ============================================================================
module tb_paddle_input_mapper;

    localparam int NP = 2;
    localparam int PW = 8;
    localparam int TD = 8;
    localparam int CL = 20;

    logic           clk_sys = 1'b0;
    logic           reset;
    logic [10:0]    ps2_key;
    logic [16*NP-1:0] joystick;
    logic [16*NP-1:0] joystick_analog;
    logic [NP-1:0]  mode_digital;
    logic           ext_coin;
    logic [PW*NP-1:0] paddle_pos;
    logic [NP-1:0]  start;
    logic           coin;

    paddle_input_mapper #(
        .NUM_PLAYERS(NP), .POS_W(PW), .POS_MIN(0), .POS_MAX(255),
        .STEP(4), .TICK_DIV(TD), .COIN_LEN(CL)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key),
        .joystick(joystick), .joystick_analog(joystick_analog),
        .mode_digital(mode_digital), .ext_coin(ext_coin),
        .paddle_pos(paddle_pos), .start(start), .coin(coin)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int    kind;   // 0 paddle, 1 start bit, 2 coin level
        int    idx;
        int    exp;
        string name;
    } chk_t;

    chk_t chk_q[$];
    int   coin_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc;
    logic r_tog;

    // Edges since reset release; the edge after a negedge ticks when cyc%TD==TD-1
    always @(posedge clk_sys or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic expect_val(input string n, input int k, input int i, input int e);
        chk_t c;
        c.kind = k; c.idx = i; c.exp = e; c.name = n;
        chk_q.push_back(c);
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic wait_tick(input int n = 1);
        for (int t = 0; t < n; t++) begin
            for (int i = 0; i < 2*TD; i++) begin
                @(negedge clk_sys);
                if (cyc % TD == TD-1) break;
            end
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic ps2(input logic [8:0] code, input logic pr);
        r_tog   = ~r_tog;
        ps2_key = {r_tog, pr, code};
    endtask

    // Level monitor: compares every queued expectation at the next negedge
    always @(negedge clk_sys) begin
        chk_t c;
        int   act;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            case (c.kind)
                0:       act = int'(paddle_pos[c.idx*PW +: PW]);
                1:       act = int'(start[c.idx]);
                default: act = int'(coin);
            endcase
            total++;
            if (act != c.exp) begin
                bad++;
                $display("FAIL %s: got %0d expected %0d", c.name, act, c.exp);
            end
        end
    end

    // Coin monitor: every completed pulse is matched against the next expected length
    int run = 0;
    always @(negedge clk_sys) begin
        if (coin) begin
            run++;
        end else if (run > 0) begin
            total++;
            if (coin_q.size() == 0) begin
                bad++;
                $display("FAIL coin_unexpected: got pulse of %0d expected none", run);
            end else begin
                int e;
                e = coin_q.pop_front();
                if (run != e) begin
                    bad++;
                    $display("FAIL coin_len: got %0d expected %0d", run, e);
                end
            end
            run = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset           = 1'b1;
        r_tog           = 1'b0;
        ps2_key         = 11'h000;
        joystick        = '0;
        joystick_analog = {8'h40, 8'h00, 8'h40, 8'h00};
        mode_digital    = 2'b00;
        ext_coin        = 1'b0;

        // Reset state and analog latency
        step(3);
        expect_val("rst_pos0", 0, 0, 127);
        expect_val("rst_pos1", 0, 1, 127);
        expect_val("rst_start", 1, 0, 0);
        expect_val("rst_coin", 2, 0, 0);
        step();
        reset = 1'b0;
        expect_val("post_rst_pos0", 0, 0, 127);
        step();
        expect_val("ana40_pos0", 0, 0, 8'hC0);
        expect_val("ana40_pos1", 0, 1, 8'hC0);

        joystick_analog = {8'h7F, 8'h00, 8'h80, 8'h00};
        step();
        expect_val("ana_m128", 0, 0, 0);
        expect_val("ana_p127", 0, 1, 255);
        joystick_analog = {8'h7A, 8'h00, 8'h00, 8'h00};
        step();
        expect_val("ana_zero", 0, 0, 128);
        expect_val("ana_7A", 0, 1, 250);
        joystick_analog = {8'h7A, 8'h00, 8'h7A, 8'h00};
        step();
        expect_val("ana_pos250", 0, 0, 250);

        // Analog -> digital switch, saturate at the top
        wait_tick();
        mode_digital[0] = 1'b1;
        joystick[2]     = 1'b1;
        joystick_analog[15:8] = 8'h00;
        step();
        expect_val("switch_hold", 0, 0, 250);
        wait_tick();
        expect_val("dn_tick1", 0, 0, 254);
        wait_tick();
        expect_val("dn_tick2", 0, 0, 255);
        wait_tick();
        expect_val("dn_sat", 0, 0, 255);

        // W key moves up; both keys hold
        joystick[2] = 1'b0;
        ps2(9'h01D, 1'b1);
        wait_tick();
        expect_val("up_tick", 0, 0, 251);
        ps2(9'h01B, 1'b1);
        wait_tick(5);
        expect_val("both_hold", 0, 0, 251);
        ps2(9'h01B, 1'b0);
        wait_tick(3);
        expect_val("up_3ticks", 0, 0, 239);
        wait_tick(62);
        expect_val("up_sat_min", 0, 0, 0);
        ps2(9'h01D, 1'b0);

        // Start from key (2 cycles) and joystick (1 cycle)
        step();
        ps2(9'h016, 1'b1);
        step();
        expect_val("start0_early", 1, 0, 0);
        step();
        expect_val("start0_key", 1, 0, 1);
        joystick[16+4] = 1'b1;
        step();
        expect_val("start1_joy", 1, 1, 1);
        ps2(9'h016, 1'b0);
        joystick[16+4] = 1'b0;
        step(2);
        expect_val("start0_rel", 1, 0, 0);
        expect_val("start1_rel", 1, 1, 0);

        // Coin: one pulse per press, re-press during pulse ignored
        ps2(9'h02E, 1'b1);
        coin_q.push_back(CL);
        step(6);
        ps2(9'h02E, 1'b0);
        step(3);
        ps2(9'h02E, 1'b1);
        step(80);
        ps2(9'h02E, 1'b0);
        step(10);
        ext_coin = 1'b1;
        coin_q.push_back(CL);
        step();
        ext_coin = 1'b0;
        step(40);

        // Reset during a pulse aborts it and recentres
        ext_coin = 1'b1;
        step(2);
        ext_coin = 1'b0;
        step(4);
        reset = 1'b1;
        coin_q.push_back(4);
        expect_val("rst_mid_coin", 2, 0, 0);
        expect_val("rst_mid_pos0", 0, 0, 127);
        expect_val("rst_mid_pos1", 0, 1, 127);
        ps2_key = {1'b1, 1'b1, 9'h016};
        r_tog   = 1'b1;
        step(2);
        reset = 1'b0;
        step(4);
        expect_val("no_evt_after_rst", 1, 0, 0);
        expect_val("ana_after_rst", 0, 1, 250);
        step(5);

        total++;
        if (coin_q.size() != 0) begin
            bad++;
            $display("FAIL coin_pending: got %0d outstanding expected 0", coin_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
